// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce filter slice.
package debounce_pkg;

  localparam int SYNC_STAGES = 2;

  // Counter must hold 0..limit-1; keep at least one bit for limit 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_filter_if.sv
// Switch input and filtered outputs of the debounce filter.
interface debounce_filter_if;

  logic i_Bouncy;
  logic o_Debounced;
  logic o_Rise;
  logic o_Fall;

  modport master (
    output i_Bouncy,
    input  o_Debounced,
    input  o_Rise,
    input  o_Fall
  );

  modport slave (
    input  i_Bouncy,
    output o_Debounced,
    output o_Rise,
    output o_Fall
  );

endinterface

// File: rtl/debounce_sync.sv
// Multi-flop synchronizer, async active-low reset, clears to 0.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int DEPTH = SYNC_STAGES
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/debounce_filter.sv
// Switch debounce filter with registered edge pulses.
// Define DEBOUNCE_SYNC_EN to add a 2-flop input synchronizer.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 20
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  debounce_filter_if.slave  bus
);

  if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
    $error("DEBOUNCE_LIMIT must be at least 1");
  end

  localparam int CW = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  logic          sample;
  logic [CW-1:0] cnt;
  logic          deb;
  logic          rise;
  logic          fall;

`ifdef DEBOUNCE_SYNC_EN
  debounce_sync #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .d       (bus.i_Bouncy),
    .q       (sample)
  );
`else
  assign sample = bus.i_Bouncy;
`endif

  // Count saturates at CNT_MAX: reaching it commits the new level.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt  <= '0;
      deb  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample != deb) begin
        if (cnt == CNT_MAX) begin
          cnt  <= '0;
          deb  <= sample;
          rise <= sample;
          fall <= ~sample;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign bus.o_Debounced = deb;
  assign bus.o_Rise      = rise;
  assign bus.o_Fall      = fall;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter (limit 4 and limit 1 instances).
module tb_debounce_filter;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT  = 4 + SYNC;
  localparam int LAT1 = 1 + SYNC;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  debounce_filter_if bus4 ();
  debounce_filter_if bus1 ();

  debounce_filter #(.DEBOUNCE_LIMIT(4)) dut4 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus4.slave)
  );

  debounce_filter #(.DEBOUNCE_LIMIT(1)) dut1 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.i_Bouncy = 1'b0;
    bus1.i_Bouncy = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus4.o_Debounced !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_deb got=%b exp=0", bus4.o_Debounced);
    end
    tests_run++;
    if (bus4.o_Rise !== 1'b0 || bus4.o_Fall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pulse got=%b%b exp=00",
               bus4.o_Rise, bus4.o_Fall);
    end
    tests_run++;
    if (bus1.o_Debounced !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_deb1 got=%b exp=0", bus1.o_Debounced);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_low();
    for (int k = 1; k <= 3; k++) begin
      bus4.i_Bouncy = 1'b0;
      tick();
      tests_run++;
      if (bus4.o_Debounced !== 1'b0 || bus4.o_Rise !== 1'b0 ||
          bus4.o_Fall !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_low k=%0d got=%b%b%b exp=000", k,
                 bus4.o_Debounced, bus4.o_Rise, bus4.o_Fall);
      end
    end
  endtask

  task automatic test_glitch_rise();
    int rises;
    rises = 0;
    bus4.i_Bouncy = 1'b1;
    tick();
    tests_run++;
    if (bus4.o_Debounced !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_hi got=%b exp=0", bus4.o_Debounced);
    end
    bus4.i_Bouncy = 1'b0;
    tick();
    tests_run++;
    if (bus4.o_Debounced !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_lo got=%b exp=0", bus4.o_Debounced);
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      logic ed;
      logic er;
      bus4.i_Bouncy = 1'b1;
      tick();
      ed = (k >= LAT);
      er = (k == LAT);
      if (bus4.o_Rise === 1'b1) rises++;
      tests_run++;
      if (bus4.o_Debounced !== ed || bus4.o_Rise !== er ||
          bus4.o_Fall !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch_rise k=%0d got=%b%b%b exp=%b%b0", k,
                 bus4.o_Debounced, bus4.o_Rise, bus4.o_Fall, ed, er);
      end
    end
    tests_run++;
    if (rises != 1) begin
      tests_failed++;
      $display("FAIL rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_fall();
    for (int k = 1; k <= LAT + 2; k++) begin
      logic ed;
      logic ef;
      bus4.i_Bouncy = 1'b0;
      tick();
      ed = (k < LAT);
      ef = (k == LAT);
      tests_run++;
      if (bus4.o_Debounced !== ed || bus4.o_Fall !== ef ||
          bus4.o_Rise !== 1'b0) begin
        tests_failed++;
        $display("FAIL fall k=%0d got=%b%b%b exp=%b0%b", k,
                 bus4.o_Debounced, bus4.o_Rise, bus4.o_Fall, ed, ef);
      end
    end
  endtask

  task automatic test_restart();
    for (int k = 1; k <= 4; k++) begin
      bus4.i_Bouncy = (k == 4) ? 1'b0 : 1'b1;
      tick();
      tests_run++;
      if (bus4.o_Debounced !== 1'b0 || bus4.o_Rise !== 1'b0) begin
        tests_failed++;
        $display("FAIL restart_pre k=%0d got=%b%b exp=00", k,
                 bus4.o_Debounced, bus4.o_Rise);
      end
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      logic ed;
      logic er;
      bus4.i_Bouncy = 1'b1;
      tick();
      ed = (k >= LAT);
      er = (k == LAT);
      tests_run++;
      if (bus4.o_Debounced !== ed || bus4.o_Rise !== er) begin
        tests_failed++;
        $display("FAIL restart k=%0d got=%b%b exp=%b%b", k,
                 bus4.o_Debounced, bus4.o_Rise, ed, er);
      end
    end
  endtask

  task automatic test_async_reset();
    bus4.i_Bouncy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus4.o_Debounced !== 1'b0 || bus4.o_Rise !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got=%b%b exp=00",
               bus4.o_Debounced, bus4.o_Rise);
    end
    tick();
    rst_n = 1'b1;
    bus4.i_Bouncy = 1'b0;
    for (int k = 1; k <= 2; k++) tick();
  endtask

  task automatic test_reset_mid();
    bus4.i_Bouncy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      tests_run++;
      if (bus4.o_Debounced !== 1'b0 || bus4.o_Rise !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_hold k=%0d got=%b%b exp=00", k,
                 bus4.o_Debounced, bus4.o_Rise);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      logic ed;
      logic er;
      tick();
      ed = (k >= LAT);
      er = (k == LAT);
      tests_run++;
      if (bus4.o_Debounced !== ed || bus4.o_Rise !== er) begin
        tests_failed++;
        $display("FAIL reset_mid_rel k=%0d got=%b%b exp=%b%b", k,
                 bus4.o_Debounced, bus4.o_Rise, ed, er);
      end
    end
  endtask

  task automatic test_limit_one();
    for (int k = 1; k <= LAT1 + 1; k++) begin
      logic ed;
      logic er;
      bus1.i_Bouncy = 1'b1;
      tick();
      ed = (k >= LAT1);
      er = (k == LAT1);
      tests_run++;
      if (bus1.o_Debounced !== ed || bus1.o_Rise !== er) begin
        tests_failed++;
        $display("FAIL limit1_rise k=%0d got=%b%b exp=%b%b", k,
                 bus1.o_Debounced, bus1.o_Rise, ed, er);
      end
    end
    for (int k = 1; k <= LAT1 + 1; k++) begin
      logic ed;
      logic ef;
      bus1.i_Bouncy = 1'b0;
      tick();
      ed = (k < LAT1);
      ef = (k == LAT1);
      tests_run++;
      if (bus1.o_Debounced !== ed || bus1.o_Fall !== ef ||
          bus1.o_Rise !== 1'b0) begin
        tests_failed++;
        $display("FAIL limit1_fall k=%0d got=%b%b%b exp=%b0%b", k,
                 bus1.o_Debounced, bus1.o_Rise, bus1.o_Fall, ed, ef);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    test_reset();
    test_idle_low();
    test_glitch_rise();
    test_fall();
    test_restart();
    test_async_reset();
    test_reset_mid();
    test_limit_one();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_LIMIT, default 20, meaning the number of consecutive clock samples the input must differ from the output before the output follows.
REQ-002 The block SHALL have port i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Rst_L  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port i_Bouncy  input  1  raw mechanical switch level.
REQ-005 The block SHALL have port o_Debounced  output  1  filtered, registered level.
REQ-006 The block SHALL have port o_Rise  output  1  one-cycle pulse coincident with o_Debounced going 0->1.
REQ-007 The block SHALL have port o_Fall  output  1  one-cycle pulse coincident with o_Debounced going 1->0.
REQ-008 The block SHALL use one clock (i_Clk) and one asynchronous active-low reset (i_Rst_L); these are fixed.

Function
REQ-009 The counter SHALL be $clog2(DEBOUNCE_LIMIT) bits wide, minimum 1 bit; DEBOUNCE_LIMIT >= 1 SHALL be legal, and 0 SHALL be a compile-time error.
REQ-010 On each edge, if the sampled input differs from o_Debounced and count < DEBOUNCE_LIMIT-1, the count SHALL increment.
REQ-011 On each edge, if the sampled input differs from o_Debounced and count == DEBOUNCE_LIMIT-1, o_Debounced SHALL take the input value and the count SHALL clear to 0.
REQ-012 On each edge, if the sampled input equals o_Debounced, the count SHALL clear to 0; any glitch therefore restarts qualification.
REQ-013 Latency SHALL be exactly DEBOUNCE_LIMIT edges: o_Debounced updates on the DEBOUNCE_LIMIT-th consecutive edge at which the differing level is sampled; with DEBOUNCE_LIMIT=1 it updates on the first such edge.
REQ-014 o_Rise and o_Fall SHALL be registered, high for exactly the one cycle in which o_Debounced holds its new value, and never high simultaneously.
REQ-015 The counter SHALL saturate at DEBOUNCE_LIMIT-1 and SHALL never wrap.
REQ-016 All outputs SHALL be driven directly from flops, with no combinational path from i_Bouncy.

Reset
REQ-017 Asserting i_Rst_L low SHALL immediately force o_Debounced=0, o_Rise=0, o_Fall=0, counter=0, and synchronizer flops=0, including mid-qualification.
REQ-018 After release, a held-high input SHALL be qualified normally: o_Rise pulses after the full latency.

Configuration
REQ-019 With macro DEBOUNCE_SYNC_EN defined, i_Bouncy SHALL pass through a 2-flop synchronizer before the filter, adding exactly 2 cycles of latency (DEBOUNCE_LIMIT+2 total).
REQ-020 With DEBOUNCE_SYNC_EN undefined, the filter SHALL sample i_Bouncy directly; the caller then guarantees synchronous input.

Structure
REQ-021 Package debounce_pkg SHALL hold the counter-width function (clog2 with minimum 1) and the synchronizer depth constant SYNC_STAGES=2.
REQ-022 The synchronizer SHALL be a separate sub-module debounce_sync (parameterised depth, async active-low reset), instantiated only under DEBOUNCE_SYNC_EN.

Verification (DEBOUNCE_LIMIT=4, DEBOUNCE_SYNC_EN undefined unless stated)
REQ-023 Input low after reset for 3 cycles -> o_Debounced=0, no pulses.
REQ-024 Input 1 for 1 cycle, 0 for 1 cycle, then 1 held 6 cycles -> o_Debounced stays 0 through the glitch, rises on the 4th edge of the stable-high run, and o_Rise pulses exactly once that cycle.
REQ-025 Input high for 3 edges, then low 1, then high 4 -> no output change until the 4th edge of the second run.
REQ-026 With o_Debounced=1, input low held 4 edges -> o_Debounced=0 on the 4th edge, and o_Fall pulses for 1 cycle.
REQ-027 Reset asserted after 2 qualifying high edges, then released with input still high -> output 0 during reset; it rises 4 edges after release.
REQ-028 With DEBOUNCE_SYNC_EN defined, a clean step 0->1 -> o_Debounced rises on the 6th edge after the step.
